activation_stream: RTL

Parametrised, pipelined successor to the fixed three-channel activation layer: applies a runtime-selectable activation (bypass, ReLU, leaky ReLU, capped ReLU) to CHANNELS parallel fixed-point samples per beat. Sits between the convolution accumulator output and the pooling stage. Uses a valid/ready handshake with full backpressure. A partially-valid beat (channel misalignment) is dropped and raises a sticky hardware error flag.

---
 rtl/act_stream_pkg.sv | 27 ++
 rtl/activation_unit.sv | 38 +++
 rtl/activation_stream.sv | 137 +++++++++++++
 3 files changed

// File: rtl/act_stream_pkg.sv
// rtl/act_stream_pkg.sv - shared types, default sizes and beat-alignment helper for activation_stream
package act_stream_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_LEAKY  = 2'b10,
    ACT_CAP    = 2'b11
  } act_mode_e;

  localparam int ACT_CHANNELS     = 3;
  localparam int ACT_DATA_W       = 16;
  localparam int ACT_SHIFT_W      = 4;
  localparam int ACT_MAX_CHANNELS = 16;

  // True when some, but not all, of the first `channels` lanes are valid.
  function automatic logic is_misaligned(input logic [ACT_MAX_CHANNELS-1:0] valid,
                                         input int channels);
    int cnt;
    cnt = 0;
    for (int i = 0; i < ACT_MAX_CHANNELS; i++) begin
      if (i < channels && valid[i]) cnt++;
    end
    return (cnt != 0) && (cnt != channels);
  endfunction

endpackage

// File: rtl/activation_unit.sv
// rtl/activation_unit.sv - combinational single-channel activation with negative/clip flags
module activation_unit
  import act_stream_pkg::*;
#(
  parameter int DATA_W  = ACT_DATA_W,
  parameter int SHIFT_W = ACT_SHIFT_W
) (
  input  logic signed [DATA_W-1:0]  x,
  input  logic [1:0]                mode,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic signed [DATA_W-1:0]  cap,
  output logic signed [DATA_W-1:0]  y,
  output logic                      is_neg,
  output logic                      is_clip
);

  logic signed [DATA_W-1:0] pos;
  logic signed [DATA_W-1:0] cap_eff;

  always_comb begin
    pos     = x[DATA_W-1] ? '0 : x;
    // A negative cap collapses to zero so capped mode never emits negatives.
    cap_eff = cap[DATA_W-1] ? '0 : cap;
    is_neg  = x[DATA_W-1] && (mode != ACT_BYPASS);
    is_clip = 1'b0;
    y       = x;
    case (mode)
      ACT_BYPASS: y = x;
      ACT_RELU:   y = pos;
      ACT_LEAKY:  y = x[DATA_W-1] ? (x >>> shift) : x;
      default: begin
        is_clip = pos > cap_eff;
        y       = (pos > cap_eff) ? cap_eff : pos;
      end
    endcase
  end

endmodule

// File: rtl/activation_stream.sv
// rtl/activation_stream.sv - two-stage activation pipeline with backpressure; ACT_STREAM_STATS_EN adds counters
module activation_stream
  import act_stream_pkg::*;
#(
  parameter int CHANNELS = ACT_CHANNELS,
  parameter int DATA_W   = ACT_DATA_W,
  parameter int SHIFT_W  = ACT_SHIFT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                cfg_mode,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic signed [DATA_W-1:0]  cfg_cap,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic signed [DATA_W-1:0]  in_data [CHANNELS],
  output logic                      in_ready,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out_data [CHANNELS],
  input  logic                      out_ready,
  output logic                      err_misalign,
  input  logic                      err_clear
`ifdef ACT_STREAM_STATS_EN
  ,
  input  logic                      stat_clear,
  output logic [31:0]               stat_neg_cnt,
  output logic [31:0]               stat_clip_cnt
`endif
);

  logic                     s1_valid;
  logic                     s2_valid;
  logic                     s1_adv;
  logic                     s2_adv;
  logic                     accept;
  logic                     partial;
  logic [ACT_MAX_CHANNELS-1:0] valid_ext;
  logic signed [DATA_W-1:0] s1_data [CHANNELS];
  logic [1:0]               s1_mode;
  logic [SHIFT_W-1:0]       s1_shift;
  logic signed [DATA_W-1:0] s1_cap;
  logic signed [DATA_W-1:0] act_y [CHANNELS];
  logic [CHANNELS-1:0]      act_neg;
  logic [CHANNELS-1:0]      act_clip;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign valid_ext = ACT_MAX_CHANNELS'(in_valid);
  assign accept    = s1_adv && (&in_valid);
  assign partial   = s1_adv && is_misaligned(valid_ext, CHANNELS);
  assign out_valid = s2_valid;

  // Configuration travels with the beat so a mode change never affects data already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_shift <= '0;
      s1_cap   <= '0;
      for (int i = 0; i < CHANNELS; i++) s1_data[i] <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_mode  <= cfg_mode;
        s1_shift <= cfg_shift;
        s1_cap   <= cfg_cap;
        for (int i = 0; i < CHANNELS; i++) s1_data[i] <= in_data[i];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_act
    activation_unit #(
      .DATA_W (DATA_W),
      .SHIFT_W(SHIFT_W)
    ) u_act (
      .x      (s1_data[c]),
      .mode   (s1_mode),
      .shift  (s1_shift),
      .cap    (s1_cap),
      .y      (act_y[c]),
      .is_neg (act_neg[c]),
      .is_clip(act_clip[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) out_data[i] <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < CHANNELS; i++) out_data[i] <= act_y[i];
      end
    end
  end

  // A fresh misalignment outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_misalign <= 1'b0;
    end else if (partial) begin
      err_misalign <= 1'b1;
    end else if (err_clear) begin
      err_misalign <= 1'b0;
    end
  end

`ifdef ACT_STREAM_STATS_EN
  logic [32:0] neg_sum;
  logic [32:0] clip_sum;

  always_comb begin
    neg_sum  = {1'b0, stat_neg_cnt} + 33'($countones(act_neg));
    clip_sum = {1'b0, stat_clip_cnt} + 33'($countones(act_clip));
  end

  // Samples are counted as they move from S1 into S2, saturating at all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_neg_cnt  <= '0;
      stat_clip_cnt <= '0;
    end else if (stat_clear) begin
      stat_neg_cnt  <= '0;
      stat_clip_cnt <= '0;
    end else if (s1_valid && s2_adv) begin
      stat_neg_cnt  <= neg_sum[32] ? '1 : neg_sum[31:0];
      stat_clip_cnt <= clip_sum[32] ? '1 : clip_sum[31:0];
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{act_neg, act_clip};
`endif

endmodule
